// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bus bundle between the fetch front end, the MMU instruction
// port, the redirect/stall controls and decode stage 1.
//   FLUSH/NEW_PC/STALL            : redirect and stall controls from downstream
//   INST_RDEN/INST_RIADDR         : pipelined in-order MMU read request
//   INST_RVALID/ROADDR/RDATA      : MMU response (address-tagged)
//   OUT_VALID/PC/DATA/COUNT       : FIFO head presented to decode, occupancy
// slave is the fetch queue side, master is the driver (controls + MMU + decode).
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          FLUSH;
    logic [31:0]   NEW_PC;
    logic          STALL;
    logic          INST_RDEN;
    logic [31:0]   INST_RIADDR;
    logic [31:0]   INST_ROADDR;
    logic          INST_RVALID;
    logic [31:0]   INST_RDATA;
    logic          OUT_VALID;
    logic [31:0]   OUT_PC;
    logic [31:0]   OUT_DATA;
    logic [CW-1:0] OUT_COUNT;

    modport slave (
        input  FLUSH, NEW_PC, STALL, INST_ROADDR, INST_RVALID, INST_RDATA,
        output INST_RDEN, INST_RIADDR, OUT_VALID, OUT_PC, OUT_DATA, OUT_COUNT
    );

    modport master (
        output FLUSH, NEW_PC, STALL, INST_ROADDR, INST_RVALID, INST_RDATA,
        input  INST_RDEN, INST_RIADDR, OUT_VALID, OUT_PC, OUT_DATA, OUT_COUNT
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Keeps up to DEPTH requests
// buffered or in flight against a pipelined in-order MMU port, buffers the
// returned instructions in a FIFO and presents the head to decode.
// Ports:
//   CLK  : clock
//   RST  : asynchronous active-high reset
//   fq   : fetch_queue_if.slave (controls, MMU request/response, decode head)
module fetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic CLK,
    input  logic RST,
    fetch_queue_if.slave fq
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   exp_q, exp_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;

    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic          issue_c;
    logic          accept_c;
    logic          pop_c;
    logic          empty_c;
    logic [CW-1:0] inflight_c;
    logic          unused_ok_c;

    // Credit: buffered + outstanding never exceeds DEPTH, so a push never overflows.
    assign inflight_c = count_q + outst_q;
    assign empty_c    = (count_q == '0);
    assign issue_c    = !RST && !fq.FLUSH && (inflight_c < CW'(DEPTH));
    // Only the next in-order address is accepted; stale responses fall through.
    assign accept_c   = fq.INST_RVALID && (fq.INST_ROADDR == exp_q) && !fq.FLUSH;
    assign pop_c      = !empty_c && !fq.STALL && !fq.FLUSH;

    assign unused_ok_c = &{1'b0, fq.NEW_PC[1:0]};

    // Next-state: flush overrides issue, accept and pop.
    always_comb begin
        pc_d    = pc_q;
        exp_d   = exp_q;
        outst_d = outst_q;
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (fq.FLUSH) begin
            pc_d    = {fq.NEW_PC[31:2], 2'b00};
            exp_d   = {fq.NEW_PC[31:2], 2'b00};
            outst_d = '0;
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            if (issue_c) begin
                pc_d = pc_q + 32'd4;
            end
            if (accept_c) begin
                exp_d = exp_q + 32'd4;
                wr_d  = wr_q + PW'(1);
            end
            if (pop_c) begin
                rd_d = rd_q + PW'(1);
            end
            count_d = count_q + CW'(accept_c) - CW'(pop_c);
            // Saturating decrement: a stale match after flush may arrive with nothing issued.
            outst_d = outst_q + CW'(issue_c) - CW'(accept_c && (outst_q != '0));
        end
    end

    // Control state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q    <= START_ADDR;
            exp_q   <= START_ADDR;
            outst_q <= '0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            exp_q   <= exp_d;
            outst_q <= outst_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge CLK) begin
        if (accept_c) begin
            pc_mem_q[wr_q]   <= fq.INST_ROADDR;
            data_mem_q[wr_q] <= fq.INST_RDATA;
        end
    end

    // Head presentation and MMU request.
    assign fq.OUT_VALID   = !empty_c;
    assign fq.OUT_PC      = empty_c ? 32'h0 : pc_mem_q[rd_q];
    assign fq.OUT_DATA    = empty_c ? NOP_INST : data_mem_q[rd_q];
    assign fq.OUT_COUNT   = count_q;
    assign fq.INST_RDEN   = issue_c;
    assign fq.INST_RIADDR = pc_q;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-request fetch stage and the valid/NOP mux in front of decode.
- Keeps up to DEPTH fetches in flight or buffered against a pipelined, in-order MMU instruction port.
- Buffers returned instructions in a FIFO and presents them to decode stage 1.
- On FLUSH, redirects to NEW_PC and discards stale responses by address check.
- Under STALL, keeps prefetching while holding its output.

Parameters:
DEPTH, 4, FIFO entries and maximum (buffered + outstanding) requests; power of 2, >= 2
START_ADDR, 32'h0000_0000, fetch PC after reset; word-aligned
NOP_INST, 32'h0000_0013, OUT_DATA value when the queue is empty

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
FLUSH  in  1  redirect request (jump taken downstream)
NEW_PC  in  32  redirect target
STALL  in  1  downstream stall (MEM_WAIT)
INST_RDEN  out  1  MMU read request, one per cycle when high
INST_RIADDR  out  32  request address
INST_ROADDR  in  32  address of the returned instruction
INST_RVALID  in  1  response valid
INST_RDATA  in  32  returned instruction
OUT_VALID  out  1  head entry valid
OUT_PC  out  32  head PC; 0 when empty
OUT_DATA  out  32  head instruction; NOP_INST when empty
OUT_COUNT  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- State: pc (next request address), exp_addr (next accepted response address), outst (issued, not yet returned), FIFO (count, rd/wr pointers), all with async reset.
- Reset values: pc = exp_addr = START_ADDR; outst = count = 0; pointers = 0.
  - Outputs during reset: OUT_VALID=0, OUT_PC=0, OUT_DATA=NOP_INST, OUT_COUNT=0, INST_RDEN=0, INST_RIADDR=START_ADDR.
- Issue (combinational): INST_RDEN = !RST && !FLUSH && (count + outst < DEPTH); INST_RIADDR = pc.
  - On issue, pc += 4 (mod 2^32) and outst += 1.
- Response accept: INST_RVALID && INST_ROADDR == exp_addr && !FLUSH.
  - Writes {ROADDR, RDATA} at wr pointer; exp_addr += 4; outst -= 1, saturating at 0.
  - Non-matching responses are dropped silently with no state change.
- A stale response that happens to match exp_addr after a flush is accepted. Instruction memory is static, so the data is identical. The genuine response for that address then mismatches and is dropped.
- The credit rule guarantees that an accepted response never finds the FIFO full. No overflow path exists.
- Output (combinational from the head entry): OUT_VALID = count != 0.
  - Pop when OUT_VALID && !STALL && !FLUSH; rd pointer advances.
  - Push and pop in the same cycle leave count unchanged.
- Latency: a response accepted at edge N is visible on OUT_* after edge N (min 1 cycle, no bypass). With a 1-cycle MMU, the first OUT_VALID appears 2 cycles after reset release.
- STALL: no pop and OUT_* held stable. Issue and accept continue until count + outst = DEPTH.
- FLUSH has priority over STALL, push, pop and issue. At the next edge:
  - pc = exp_addr = {NEW_PC[31:2], 2'b00};
  - count = outst = 0, pointers = 0.
  - In the flush cycle itself, INST_RDEN = 0 and the response is dropped.
  - In the cycle after the flush, INST_RIADDR = new target and OUT_VALID = 0.
- Pointers wrap modulo DEPTH. pc wraps 0xFFFF_FFFC -> 0x0000_0000.
- RST asserted mid-operation forces all state to reset values immediately. In-flight responses after release are dropped unless they match START_ADDR sequencing.

Test Plan:
- DEPTH=4, 1-cycle MMU, no stall/flush after reset release -> INST_RIADDR 0x0,0x4,0x8,...; OUT_VALID from cycle 2; OUT_PC 0x0,0x4,0x8 on consecutive cycles; OUT_DATA matches memory.
- STALL held 6 cycles in steady state -> INST_RDEN drops once count + outst = 4; OUT_PC/OUT_DATA frozen; OUT_COUNT reaches 4. After release, PCs continue contiguously with none lost or duplicated.
- FLUSH with NEW_PC=0x100 while 3 requests outstanding (3-cycle MMU) -> next cycle OUT_VALID=0, INST_RIADDR=0x100; stale responses for old addresses dropped; first OUT_PC=0x100, then 0x104.
- FLUSH and STALL asserted together with NEW_PC=0x202 -> flush wins; fetch restarts at 0x200; queue empty; OUT_DATA=0x0000_0013.
- Random MMU latency 1..4, in-order, 1000 instructions with random STALL/FLUSH -> OUT_PC strictly +4 between flushes and equal to the flush target after each; outst never exceeds 4; count + outst never exceeds DEPTH.
- RST pulsed mid-stream for a partial cycle -> outputs immediately at reset values; after release, fetch restarts at START_ADDR; late responses for old addresses are ignored.
